time_keeper: RTL and testbench
==============================

# time_keeper

Time-of-day core for the digital clock: divides the system clock to a 1 Hz tick, keeps hours/minutes/seconds as six BCD digits, and provides a two-button hour/minute set mode with blinking of the digits being edited. Sits directly upstream of the six seven-segment decoders. Each `*_ones`/`*_tens` digit drives a decoder's `data` input, and the matching `digit_en` bit drives that decoder's `Enable` input. Decoder `Mode` is tied to 0 (hexadecimal) by the top level.

## Interface
- `CLK_HZ`, default 50_000_000: clk cycles per second; must be an even number, at least 2. Simulation uses small values such as 4.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `btn_mode`  in  1  single-cycle pulse, already debounced and edge-detected; advances the set-mode state
- `btn_inc`  in  1  single-cycle pulse, already debounced and edge-detected; increments the field being edited
- `sec_ones`, `sec_tens`, `min_ones`, `min_tens`, `hr_ones`, `hr_tens`  out  4 each  BCD time digits
- `digit_en`  out  6  per-digit display enable; bit0 = `sec_ones` … bit5 = `hr_tens`
- `mode`  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN
- `tick_1hz`  out  1  one-cycle pulse when the prescaler wraps

Clocking and reset (decided): one clock; reset is synchronous and active-high; the clock port is `clk` and the reset port is `rst`.

## Operation
- **Prescaler**
  - `cnt` counts 0..CLK_HZ-1 and wraps to 0.
  - `tick_1hz` = (cnt == CLK_HZ-1), decoded from the register.
  - The prescaler runs in every state.
- **State machine**
  - RUN –btn_mode→ SET_HR –btn_mode→ SET_MIN –btn_mode→ RUN.
  - The state is unchanged when btn_mode = 0.
  - The 2'b11 encoding is unreachable; if it occurs, the next state is RUN.
- **RUN**
  - On a tick cycle, time advances one second at that edge.
  - sec 59→00 carries into min; min 59→00 carries into hr; hr 23→00.
  - 23:59:59 → 00:00:00.
  - btn_inc is ignored.
- **SET_HR / SET_MIN**
  - Time does not advance on tick.
  - btn_inc in SET_HR: hr = (hr+1) mod 24. Minutes and seconds are unchanged.
  - btn_inc in SET_MIN: min = (min+1) mod 60. No carry into hours; seconds are unchanged.
- **Exit SET_MIN → RUN**
  - At the same edge, seconds are set to 00 and cnt to 0, so the first tick follows CLK_HZ cycles later.
- **Simultaneous events**
  - btn_mode and btn_inc in the same cycle: the transition happens and the increment is dropped.
  - btn_mode in RUN on a tick cycle: the second still advances, and the state goes to SET_HR.
- **BCD rules**
  - Each field is held as a tens/ones digit pair.
  - ones 9→0 increments tens.
  - Digits are never outside 0–9; tens digits never exceed their limits (sec/min 5, hr 2).
- **Blink**
  - blink_on = (cnt < CLK_HZ/2), giving a 1 Hz blink with 50% duty.
  - RUN: digit_en = 6'b111111.
  - SET_HR: bits[5:4] = blink_on; the other bits are 1.
  - SET_MIN: bits[3:2] = blink_on; the other bits are 1.

## Timing
- Registered: the time digits, the state, and cnt.
- `tick_1hz`, `mode` and `digit_en` are decoded from registers, with no input-to-output combinational path.
- Time digits and `mode` take their new value the cycle after the causing tick or pulse.
- `digit_en` follows cnt in the same cycle.
- Reset (while `rst` is high, and the cycle after it falls):
  - all digits 0, mode 0, cnt 0, tick_1hz 0, digit_en 6'b111111.
  - Reset overrides btn_* and tick in the same cycle.
  - Reset during SET_HR or SET_MIN returns to RUN with 00:00:00.
- With CLK_HZ = N:
  - the first tick_1hz after reset release occurs on the N-th cycle (cnt = N-1);
  - sec_ones = 1 is visible on the following cycle.

## Test plan
All scenarios use CLK_HZ = 4.
1. **Reset and first tick.** Assert rst for 2 cycles, then release.
   - Required: all digits 0, mode 0, digit_en 111111.
   - tick_1hz high on the 4th cycle after release; sec_ones = 1 on the next cycle.
   - After 60 ticks, min_ones = 1 and sec = 00.
2. **Set time and full rollover.**
   - Stimulus: btn_mode, 23×btn_inc, btn_mode, 59×btn_inc, btn_mode.
   - Required: time reads 23:59:00 and mode = 0.
   - After 60 further ticks, all digits are 00:00:00.
3. **Set-mode wraps.**
   - 24 btn_inc in SET_HR: hr returns to its start value.
   - 60 btn_inc in SET_MIN: min returns to its start value, with no change to hr.
   - Ticks during set: seconds do not change.
4. **Blink pattern.**
   - In SET_HR: digit_en = 111111 while cnt is 0–1, and 001111 while cnt is 2–3.
   - In SET_MIN: 110011 during cnt 2–3.
   - In RUN: constant 111111.
5. **Simultaneous btn_mode + btn_inc in SET_HR.** Required: mode becomes 2, hr unchanged.
   - Also: btn_mode on a RUN tick cycle advances the second and enters SET_HR.
6. **Reset mid-edit.** Enter SET_MIN, apply 5 btn_inc, then pulse rst. Required: mode 0, 00:00:00, digit_en 111111.

Source files
------------

// File: rtl/time_keeper.sv
// Time-of-day core: 1 Hz prescaler, BCD hh:mm:ss counter and a two-button
// hour/minute set mode with blinking of the field being edited.
module time_keeper #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] hr_tens,
    output logic [5:0] digit_en,
    output logic [1:0] mode,
    output logic       tick_1hz
);

    localparam int CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_HZ / 2);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    state_t        state_r, state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [7:0]    sec_r, min_r, hr_r;
    logic [7:0]    sec_nx_s, min_nx_s, hr_nx_s;
    logic          tick_s, blink_on_s, cnt_clr_s;
    logic [5:0]    digit_en_s;

    // BCD pair increment wrapping 59 -> 00; digits stay within 0-9 / 0-5.
    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] >= 4'd5) begin
                r[7:4] = 4'd0;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD pair increment wrapping 23 -> 00.
    function automatic logic [7:0] inc_mod24(input logic [7:0] v);
        logic [7:0] r;
        if ((v[7:4] >= 4'd2) && (v[3:0] >= 4'd3)) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign tick_s     = (cnt_r == CNT_MAX);
    assign blink_on_s = (cnt_r < CNT_HALF);

    // Next-state decode for the set-mode sequence; 2'b11 recovers to RUN.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (btn_mode) state_nx_s = ST_SET_HR;
                else          state_nx_s = ST_RUN;
            end
            ST_SET_HR: begin
                if (btn_mode) state_nx_s = ST_SET_MIN;
                else          state_nx_s = ST_SET_HR;
            end
            ST_SET_MIN: begin
                if (btn_mode) state_nx_s = ST_RUN;
                else          state_nx_s = ST_SET_MIN;
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // Time update: counting in RUN, editing in set modes; a mode press drops the increment.
    always_comb begin
        sec_nx_s  = sec_r;
        min_nx_s  = min_r;
        hr_nx_s   = hr_r;
        cnt_clr_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (tick_s) begin
                    sec_nx_s = inc_mod60(sec_r);
                    if (sec_r == 8'h59) begin
                        min_nx_s = inc_mod60(min_r);
                        if (min_r == 8'h59) hr_nx_s = inc_mod24(hr_r);
                        else                hr_nx_s = hr_r;
                    end else begin
                        min_nx_s = min_r;
                    end
                end else begin
                    sec_nx_s = sec_r;
                end
            end
            ST_SET_HR: begin
                if (btn_mode)     hr_nx_s = hr_r;
                else if (btn_inc) hr_nx_s = inc_mod24(hr_r);
                else              hr_nx_s = hr_r;
            end
            ST_SET_MIN: begin
                if (btn_mode) begin
                    sec_nx_s  = 8'h00;
                    cnt_clr_s = 1'b1;
                end else if (btn_inc) begin
                    min_nx_s = inc_mod60(min_r);
                end else begin
                    min_nx_s = min_r;
                end
            end
            default: begin
                sec_nx_s = sec_r;
            end
        endcase
    end

    // State, prescaler and time registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
            sec_r   <= 8'h00;
            min_r   <= 8'h00;
            hr_r    <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            if (cnt_clr_s || tick_s) cnt_r <= '0;
            else                     cnt_r <= cnt_r + CW'(1);
            sec_r <= sec_nx_s;
            min_r <= min_nx_s;
            hr_r  <= hr_nx_s;
        end
    end

    // Blink the pair being edited; everything else stays lit.
    always_comb begin
        digit_en_s = 6'b111111;
        case (state_r)
            ST_SET_HR:  digit_en_s[5:4] = {2{blink_on_s}};
            ST_SET_MIN: digit_en_s[3:2] = {2{blink_on_s}};
            default:    digit_en_s = 6'b111111;
        endcase
    end

    assign sec_ones = sec_r[3:0];
    assign sec_tens = sec_r[7:4];
    assign min_ones = min_r[3:0];
    assign min_tens = min_r[7:4];
    assign hr_ones  = hr_r[3:0];
    assign hr_tens  = hr_r[7:4];
    assign digit_en = digit_en_s;
    assign mode     = state_r;
    assign tick_1hz = tick_s;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with CLK_HZ = 4; expected values hand-derived.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
    logic [5:0] digit_en;
    logic [1:0] mode;
    logic       tick_1hz;
    logic [23:0] tod;
    int n_cmp = 0;
    int n_err = 0;

    time_keeper #(.CLK_HZ(4)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .hr_ones(hr_ones), .hr_tens(hr_tens),
        .digit_en(digit_en), .mode(mode), .tick_1hz(tick_1hz)
    );

    assign tod = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After this returns the prescaler sits at 0 and time is 00:00:00.
    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step();
            btn_inc = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (tod !== 24'h000000) begin n_err++; $display("FAIL reset_tod got %h want 000000", tod); end
        n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode got %0d want 0", mode); end
        n_cmp++; if (digit_en !== 6'b111111) begin n_err++; $display("FAIL reset_en got %b want 111111", digit_en); end
        n_cmp++; if (tick_1hz !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", tick_1hz); end
        step(2);
        n_cmp++; if (tick_1hz !== 1'b0) begin n_err++; $display("FAIL early_tick got %b want 0", tick_1hz); end
        step();
        n_cmp++; if (tick_1hz !== 1'b1) begin n_err++; $display("FAIL first_tick got %b want 1", tick_1hz); end
        n_cmp++; if (tod !== 24'h000000) begin n_err++; $display("FAIL pre_tick_tod got %h want 000000", tod); end
        step();
        n_cmp++; if (tod !== 24'h000001) begin n_err++; $display("FAIL first_sec got %h want 000001", tod); end
        n_cmp++; if (tick_1hz !== 1'b0) begin n_err++; $display("FAIL tick_width got %b want 0", tick_1hz); end
        step(59 * 4);
        n_cmp++; if (tod !== 24'h000100) begin n_err++; $display("FAIL sixty_ticks got %h want 000100", tod); end
    endtask

    task automatic test_set_rollover();
        do_reset();
        pulse_mode();
        pulse_inc(23);
        n_cmp++; if (tod !== 24'h230000) begin n_err++; $display("FAIL set_hr23 got %h want 230000", tod); end
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        n_cmp++; if (tod !== 24'h235900) begin n_err++; $display("FAIL set_235900 got %h want 235900", tod); end
        n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL set_exit_mode got %0d want 0", mode); end
        step(3);
        n_cmp++; if (tick_1hz !== 1'b1) begin n_err++; $display("FAIL exit_tick got %b want 1", tick_1hz); end
        step();
        n_cmp++; if (tod !== 24'h235901) begin n_err++; $display("FAIL exit_first_sec got %h want 235901", tod); end
        step(58 * 4);
        n_cmp++; if (tod !== 24'h235959) begin n_err++; $display("FAIL pre_roll got %h want 235959", tod); end
        step(4);
        n_cmp++; if (tod !== 24'h000000) begin n_err++; $display("FAIL rollover got %h want 000000", tod); end
    endtask

    task automatic test_set_wraps();
        do_reset();
        pulse_mode();
        pulse_inc(5);
        pulse_inc(19);
        n_cmp++; if (tod !== 24'h000000) begin n_err++; $display("FAIL hr_23_to_00 got %h want 000000", tod); end
        pulse_inc(5);
        n_cmp++; if (tod !== 24'h050000) begin n_err++; $display("FAIL hr_wrap24 got %h want 050000", tod); end
        pulse_mode();
        pulse_inc(7);
        pulse_inc(60);
        n_cmp++; if (tod !== 24'h050700) begin n_err++; $display("FAIL min_wrap60 got %h want 050700", tod); end
        step(9);
        n_cmp++; if (tod !== 24'h050700) begin n_err++; $display("FAIL set_no_tick got %h want 050700", tod); end
        n_cmp++; if (mode !== 2'd2) begin n_err++; $display("FAIL wrap_mode got %0d want 2", mode); end
    endtask

    task automatic test_blink();
        logic [5:0] exp_hr [4];
        exp_hr = '{6'b111111, 6'b001111, 6'b001111, 6'b111111};
        do_reset();
        pulse_mode();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (digit_en !== exp_hr[i]) begin n_err++; $display("FAIL blink_hr%0d got %b want %b", i, digit_en, exp_hr[i]); end
            step();
        end
        do_reset();
        pulse_mode();
        pulse_mode();
        n_cmp++; if (digit_en !== 6'b110011) begin n_err++; $display("FAIL blink_min2 got %b want 110011", digit_en); end
        step();
        n_cmp++; if (digit_en !== 6'b110011) begin n_err++; $display("FAIL blink_min3 got %b want 110011", digit_en); end
        step();
        n_cmp++; if (digit_en !== 6'b111111) begin n_err++; $display("FAIL blink_min0 got %b want 111111", digit_en); end
        pulse_mode();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (digit_en !== 6'b111111) begin n_err++; $display("FAIL blink_run%0d got %b want 111111", i, digit_en); end
            step();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse_mode();
        pulse_inc(3);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        n_cmp++; if (mode !== 2'd2) begin n_err++; $display("FAIL simul_mode got %0d want 2", mode); end
        n_cmp++; if (tod !== 24'h030000) begin n_err++; $display("FAIL simul_hr got %h want 030000", tod); end
        do_reset();
        step(3);
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        n_cmp++; if (tod !== 24'h000001) begin n_err++; $display("FAIL tick_mode_sec got %h want 000001", tod); end
        n_cmp++; if (mode !== 2'd1) begin n_err++; $display("FAIL tick_mode_mode got %0d want 1", mode); end
        pulse_inc(1);
        n_cmp++; if (tod !== 24'h010001) begin n_err++; $display("FAIL tick_mode_inc got %h want 010001", tod); end
    endtask

    task automatic test_reset_mid_edit();
        do_reset();
        pulse_mode();
        pulse_inc(2);
        pulse_mode();
        pulse_inc(5);
        n_cmp++; if (tod !== 24'h020500) begin n_err++; $display("FAIL edit_before got %h want 020500", tod); end
        rst = 1'b1;
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL rst_edit_mode got %0d want 0", mode); end
        n_cmp++; if (tod !== 24'h000000) begin n_err++; $display("FAIL rst_edit_tod got %h want 000000", tod); end
        n_cmp++; if (digit_en !== 6'b111111) begin n_err++; $display("FAIL rst_edit_en got %b want 111111", digit_en); end
        rst = 1'b0;
        step();
        n_cmp++; if (tod !== 24'h000000) begin n_err++; $display("FAIL rst_after_tod got %h want 000000", tod); end
        n_cmp++; if (tick_1hz !== 1'b0) begin n_err++; $display("FAIL rst_after_tick got %b want 0", tick_1hz); end
    endtask

    initial begin
        test_reset();
        test_set_rollover();
        test_set_wraps();
        test_blink();
        test_simultaneous();
        test_reset_mid_edit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
